sram_vga_responder: RTL and testbench
=====================================

// Module: sram_vga_responder
// PURPOSE
//  Memory-side responder for the framebuffer fetch handshake (vga_re/vga_addr -> vga_data/vga_success).
//  Serves those fetches from the external 16-bit async SRAM, which is shared with the CPU data port.
//  Round-robin arbitration between the VGA port and the CPU port; one SRAM access at a time.
//  Sits between vga_control, the CPU bus bridge and the board SRAM pins.
// PARAMETERS
//  ADDR_W        20        SRAM word-address width
//  WAIT_CYCLES   2         cycles OE_n/WE_n held low per access (>=1)
//  SUCCESS_HOLD  3         cycles vga_success held high with vga_data stable (>=2)
//  VGA_BASE      20'h40000 SRAM word address of framebuffer byte 0
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-low reset (0 = reset)
//  vga_re       in   1       VGA fetch request, level
//  vga_addr     in   23      framebuffer byte address (even)
//  vga_data     out  16      fetched word; [7:0] = even byte
//  vga_success  out  1       fetched word valid
//  cpu_req      in   1       CPU access request, held until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  SRAM word address
//  cpu_be       in   2       byte enables, active high
//  cpu_wdata    in   16      write data
//  cpu_rdata    out  16      read data, valid while cpu_ack=1
//  cpu_ack      out  1       one-cycle completion pulse
//  sram_addr    out  ADDR_W  SRAM address
//  sram_dq_i    in   16      SRAM data in (from pad)
//  sram_dq_o    out  16      SRAM data out (to pad)
//  sram_dq_oe   out  1       pad output enable
//  sram_ce_n    out  1       chip enable, active low
//  sram_oe_n    out  1       output enable, active low
//  sram_we_n    out  1       write enable, active low
//  sram_be_n    out  2       byte enables, active low
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; vga_success=0, vga_data=0, cpu_ack=0, cpu_rdata=0,
//    sram_ce_n/oe_n/we_n=1, sram_be_n=2'b11, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, last_grant=CPU.
//  - FSM: IDLE, RD, WR_SETUP, WR, WR_HOLD, VGA_HOLD, VGA_GAP. All outputs registered.
//  - IDLE: requesters = vga_re, cpu_req. Both set -> grant the one not granted last; one set -> grant it.
//    Grant latches address/data/be. VGA word address = VGA_BASE + vga_addr[22:1] (mod 2^ADDR_W), be_n=00.
//  - RD: WAIT_CYCLES cycles, ce_n=oe_n=0, dq_oe=0; sram_dq_i captured on last RD cycle.
//    VGA grant -> VGA_HOLD; CPU grant -> cpu_ack=1 + cpu_rdata for 1 cycle -> IDLE.
//  - CPU write: WR_SETUP (1 cycle, ce_n=0, addr/data/be driven, dq_oe=1, we_n=1) -> WR (WAIT_CYCLES, we_n=0)
//    -> WR_HOLD (1 cycle, we_n=1, data still driven, cpu_ack=1) -> IDLE. be=00 still runs the cycle; no bytes written.
//  - Latency (grant in cycle t, W=WAIT_CYCLES, H=SUCCESS_HOLD):
//    VGA read: vga_success cycles t+W+1..t+W+H.
//    CPU read: cpu_ack at t+W+1.
//    CPU write: cpu_ack at t+W+2.
//  - VGA_HOLD: vga_success=1 for exactly H cycles; vga_data frozen. vga_addr changes during hold are ignored
//    (the requester advances vga_addr on the first success cycle). Then VGA_GAP: 1 cycle, success=0 -> IDLE.
//    A still-high vga_re re-arbitrates with the new vga_addr. Result: success drops >=1 cycle between words.
//  - vga_re falls during RD: access completes, no success pulse, VGA_GAP -> IDLE.
//    vga_re falls during VGA_HOLD: success deasserts next cycle -> VGA_GAP.
//  - cpu_req must be held until cpu_ack; a drop mid-access does not abort it.
//  - SRAM idle between accesses: ce_n=oe_n=we_n=1, dq_oe=0. dq_oe never 1 while oe_n=0.
//  - Reset mid-access: outputs go to reset values immediately; the in-flight access is lost.
// STRUCTURE
//  - sram_vga_defs.vh: FSM state localparams (3-bit), GRANT_VGA/GRANT_CPU, default timing constants.
//  - One sub-module, sram_phy_timer: wait-cycle down-counter (load W, done flag). Arbiter and FSM inline.
// TESTING
//  1. W=2,H=3; vga_re=1, vga_addr=0, SRAM[0x40000]=16'hA55A -> sram_addr=0x40000; success t+3..t+5; vga_data=A55A; success=0 at t+6.
//  2. Requester advances vga_addr 0->2 on first success -> next read at 0x40001; never two success phases without a 0 cycle.
//  3. CPU write addr=0x00010, be=2'b01, wdata=16'h1234 -> we_n low 2 cycles, be_n=2'b10, ack at t+4;
//     CPU read of 0x00010 -> rdata[7:0]=8'h34 (upper byte unchanged), ack at t+3.
//  4. vga_re and cpu_req rise same cycle after a CPU grant -> VGA granted first, CPU next; sustained both -> strict alternation.
//  5. vga_re dropped in RD cycle 1 -> no vga_success pulse, VGA_GAP, then IDLE; pending cpu_req served next.
//  6. rst=0 mid-WR -> we_n=1, dq_oe=0, ce_n=1 in the same cycle (async); after release, state IDLE, all acks 0.

Source files
------------

// File: rtl/sram_vga_responder_pkg.sv
// sram_vga_responder_pkg: FSM states, grant encoding and default timing for the SRAM/VGA responder
package sram_vga_responder_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR, WR_HOLD, VGA_HOLD, VGA_GAP} state_t;
    localparam logic GRANT_VGA = 1'b1;
    localparam logic GRANT_CPU = 1'b0;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_WAIT = 2;
    localparam int DEF_HOLD = 3;
endpackage

// File: rtl/sram_phy_timer.sv
// sram_phy_timer: loadable down-counter; done marks the last cycle of a loaded interval
module sram_phy_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= load ? value : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
    assign done = cnt == 8'd1;
endmodule

// File: rtl/sram_vga_responder.sv
// sram_vga_responder: round-robin VGA/CPU arbiter and timing FSM for a shared 16-bit async SRAM
module sram_vga_responder
    import sram_vga_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT,
    parameter int SUCCESS_HOLD = DEF_HOLD,
    parameter logic [ADDR_W-1:0] VGA_BASE = 'h40000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_re,
    input  logic [22:0]       vga_addr,
    output logic [15:0]       vga_data,
    output logic              vga_success,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        sram_be_n
);
    state_t state, state_nx;
    logic gnt, gnt_nx, last, last_nx, drop, drop_nx, load, done, ack_nx, success_nx;
    logic cpu_live, pick_vga, pick_cpu;
    logic [15:0] data_nx, rdata_nx, dqo_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [1:0] be_nx;
    logic [22:0] vga_sum;

    assign vga_sum = 23'(VGA_BASE) + (vga_addr >> 1);
    // a CPU read acks while already back in IDLE, so its still-held request must not re-arbitrate
    assign cpu_live = cpu_req & ~cpu_ack;
    assign pick_vga = vga_re & (~cpu_live | last == GRANT_CPU);
    assign pick_cpu = cpu_live & ~pick_vga;

    sram_phy_timer u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(state == RD ? 8'(SUCCESS_HOLD) : 8'(WAIT_CYCLES)),
        .done(done)
    );

    always_comb begin
        state_nx = state;
        gnt_nx = gnt;
        last_nx = last;
        drop_nx = drop;
        load = 1'b0;
        ack_nx = 1'b0;
        success_nx = 1'b0;
        data_nx = vga_data;
        rdata_nx = cpu_rdata;
        addr_nx = sram_addr;
        dqo_nx = sram_dq_o;
        be_nx = sram_be_n;
        case (state)
            IDLE: if (pick_vga) begin
                state_nx = RD;
                gnt_nx = GRANT_VGA;
                last_nx = GRANT_VGA;
                drop_nx = 1'b0;
                load = 1'b1;
                addr_nx = ADDR_W'(vga_sum);
                be_nx = 2'b00;
            end else if (pick_cpu) begin
                state_nx = cpu_we ? WR_SETUP : RD;
                gnt_nx = GRANT_CPU;
                last_nx = GRANT_CPU;
                drop_nx = 1'b0;
                load = ~cpu_we;
                addr_nx = cpu_addr;
                be_nx = ~cpu_be;
                dqo_nx = cpu_wdata;
            end
            RD: begin
                drop_nx = drop | (gnt == GRANT_VGA & ~vga_re);
                if (done && gnt == GRANT_CPU) begin
                    state_nx = IDLE;
                    ack_nx = 1'b1;
                    rdata_nx = sram_dq_i;
                end else if (done) begin
                    state_nx = drop_nx ? VGA_GAP : VGA_HOLD;
                    success_nx = ~drop_nx;
                    data_nx = drop_nx ? vga_data : sram_dq_i;
                    load = ~drop_nx;
                end
            end
            WR_SETUP: begin
                state_nx = WR;
                load = 1'b1;
            end
            WR: if (done) begin
                state_nx = WR_HOLD;
                ack_nx = 1'b1;
            end
            WR_HOLD: state_nx = IDLE;
            VGA_HOLD: begin
                state_nx = (done || !vga_re) ? VGA_GAP : VGA_HOLD;
                success_nx = !done && vga_re;
            end
            VGA_GAP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            gnt <= GRANT_CPU;
            last <= GRANT_CPU;
            drop <= 1'b0;
            vga_data <= '0;
            vga_success <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack <= 1'b0;
            sram_addr <= '0;
            sram_dq_o <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 2'b11;
        end else begin
            state <= state_nx;
            gnt <= gnt_nx;
            last <= last_nx;
            drop <= drop_nx;
            vga_data <= data_nx;
            vga_success <= success_nx;
            cpu_rdata <= rdata_nx;
            cpu_ack <= ack_nx;
            sram_addr <= addr_nx;
            sram_dq_o <= dqo_nx;
            sram_dq_oe <= state_nx inside {WR_SETUP, WR, WR_HOLD};
            sram_ce_n <= !(state_nx inside {RD, WR_SETUP, WR, WR_HOLD});
            sram_oe_n <= state_nx != RD;
            sram_we_n <= state_nx != WR;
            sram_be_n <= be_nx;
        end
endmodule

// File: tb/tb_sram_vga_responder.sv
// tb_sram_vga_responder: directed checks of arbitration, access timing and reset behaviour
module tb_sram_vga_responder;
    logic clk = 1'b0;
    logic rst;
    logic vga_re, cpu_req, cpu_we;
    logic [22:0] vga_addr;
    logic [19:0] cpu_addr, sram_addr;
    logic [1:0] cpu_be, sram_be_n;
    logic [15:0] cpu_wdata, cpu_rdata, vga_data, sram_dq_i, sram_dq_o;
    logic vga_success, cpu_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] mem [256];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_vga_responder dut (
        .clk(clk), .rst(rst),
        .vga_re(vga_re), .vga_addr(vga_addr), .vga_data(vga_data), .vga_success(vga_success),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // SRAM model decodes only the low 8 address bits; test addresses are distinct there
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
    always @(posedge clk)
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hFFFF;
            mem[0] <= 16'hA55A;
            mem[1] <= 16'h7E81;
            mem[2] <= 16'h1357;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0] <= sram_dq_o[7:0];
            if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        vga_re = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = 2'b00; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_success", vga_success, 0);
        chk("rst_vdata", vga_data, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ce", sram_ce_n, 1);
        chk("rst_oe", sram_oe_n, 1);
        chk("rst_we", sram_we_n, 1);
        chk("rst_be", sram_be_n, 2'b11);
        chk("rst_dqoe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dqo", sram_dq_o, 0);
        rst = 1'b1;
        tick();
        // VGA read of byte 0 -> word 0x40000
        vga_re = 1'b1; vga_addr = 23'd0;
        tick();
        chk("t1_addr", sram_addr, 'h40000);
        chk("t1_ce", sram_ce_n, 0);
        chk("t1_oe", sram_oe_n, 0);
        chk("t1_dqoe", sram_dq_oe, 0);
        chk("t1_be", sram_be_n, 2'b00);
        tick();
        chk("t1_succ_t2", vga_success, 0);
        tick();
        chk("t1_succ_t3", vga_success, 1);
        chk("t1_data", vga_data, 16'hA55A);
        vga_addr = 23'd2;
        tick();
        chk("t1_succ_t4", vga_success, 1);
        chk("t1_data_frozen", vga_data, 16'hA55A);
        chk("t1_ce_idle", sram_ce_n, 1);
        tick();
        chk("t1_succ_t5", vga_success, 1);
        tick();
        chk("t1_succ_t6", vga_success, 0);
        tick();
        chk("t2_succ_t7", vga_success, 0);
        tick();
        chk("t2_addr", sram_addr, 'h40001);
        chk("t2_ce", sram_ce_n, 0);
        repeat (2) tick();
        chk("t2_succ", vga_success, 1);
        chk("t2_data", vga_data, 16'h7E81);
        vga_re = 1'b0;
        tick();
        chk("t2_drop_hold", vga_success, 0);
        tick();
        chk("t2_idle_ce", sram_ce_n, 1);
        // CPU write of low byte
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00010; cpu_be = 2'b01; cpu_wdata = 16'h1234;
        tick();
        chk("t3_setup_ce", sram_ce_n, 0);
        chk("t3_setup_we", sram_we_n, 1);
        chk("t3_setup_dqoe", sram_dq_oe, 1);
        chk("t3_setup_be", sram_be_n, 2'b10);
        chk("t3_setup_addr", sram_addr, 'h10);
        chk("t3_setup_dqo", sram_dq_o, 16'h1234);
        tick();
        chk("t3_we_1", sram_we_n, 0);
        chk("t3_oe_hi", sram_oe_n, 1);
        tick();
        chk("t3_we_2", sram_we_n, 0);
        chk("t3_ack_early", cpu_ack, 0);
        tick();
        chk("t3_hold_we", sram_we_n, 1);
        chk("t3_ack", cpu_ack, 1);
        chk("t3_hold_dqoe", sram_dq_oe, 1);
        cpu_req = 1'b0;
        tick();
        chk("t3_ack_drop", cpu_ack, 0);
        chk("t3_idle_dqoe", sram_dq_oe, 0);
        chk("t3_idle_ce", sram_ce_n, 1);
        // CPU read back
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11;
        tick();
        chk("t3r_oe", sram_oe_n, 0);
        chk("t3r_dqoe", sram_dq_oe, 0);
        tick();
        chk("t3r_ack_early", cpu_ack, 0);
        tick();
        chk("t3r_ack", cpu_ack, 1);
        chk("t3r_rdata", cpu_rdata, 16'hFF34);
        cpu_req = 1'b0;
        tick();
        chk("t3r_ack_drop", cpu_ack, 0);
        // simultaneous requests after a CPU grant: VGA first, then alternate
        vga_re = 1'b1; vga_addr = 23'd4; cpu_req = 1'b1;
        tick();
        chk("t4_vga_first", sram_addr, 'h40002);
        repeat (2) tick();
        chk("t4_succ", vga_success, 1);
        chk("t4_data", vga_data, 16'h1357);
        repeat (3) tick();
        chk("t4_gap", vga_success, 0);
        repeat (2) tick();
        chk("t4_cpu_next", sram_addr, 'h10);
        chk("t4_cpu_oe", sram_oe_n, 0);
        repeat (2) tick();
        chk("t4_ack", cpu_ack, 1);
        chk("t4_rdata", cpu_rdata, 16'hFF34);
        tick();
        chk("t4_vga_again", sram_addr, 'h40002);
        repeat (7) tick();
        chk("t4_cpu_again", sram_addr, 'h10);
        repeat (2) tick();
        chk("t4_ack2", cpu_ack, 1);
        cpu_req = 1'b0; vga_re = 1'b0;
        tick();
        chk("t4_idle", sram_ce_n, 1);
        // VGA aborted mid-read, pending CPU read served next
        vga_re = 1'b1; vga_addr = 23'd0; cpu_req = 1'b1;
        tick();
        chk("t5_vga_grant", sram_addr, 'h40000);
        vga_re = 1'b0;
        repeat (2) tick();
        chk("t5_gap_succ", vga_success, 0);
        chk("t5_gap_ce", sram_ce_n, 1);
        tick();
        chk("t5_idle_succ", vga_success, 0);
        tick();
        chk("t5_cpu_addr", sram_addr, 'h10);
        repeat (2) tick();
        chk("t5_ack", cpu_ack, 1);
        chk("t5_vdata_kept", vga_data, 16'h1357);
        cpu_req = 1'b0;
        tick();
        // async reset in the middle of a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00020; cpu_be = 2'b11; cpu_wdata = 16'hBEEF;
        repeat (2) tick();
        chk("t6_we_low", sram_we_n, 0);
        #1 rst = 1'b0;
        #1;
        chk("t6_we", sram_we_n, 1);
        chk("t6_dqoe", sram_dq_oe, 0);
        chk("t6_ce", sram_ce_n, 1);
        chk("t6_be", sram_be_n, 2'b11);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 20'h00010;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t6_ack", cpu_ack, 0);
        chk("t6_succ", vga_success, 0);
        chk("t6_ce_idle", sram_ce_n, 1);
        cpu_req = 1'b1;
        tick();
        chk("t6_read_oe", sram_oe_n, 0);
        repeat (2) tick();
        chk("t6_read_ack", cpu_ack, 1);
        chk("t6_read_data", cpu_rdata, 16'hFFFF);
        cpu_req = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
